// File: rtl/ser_par_frame_collect_if.sv
// Beat-in / frame-out bus of the serial-to-parallel frame collector.
// The slave modport is the collector's view; master is the source/consumer side.
interface ser_par_frame_collect_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int FRAME_LEN  = 16,
  parameter int CNT_W      = 16
);
  logic                        i_valid;
  logic [LANES*DATA_WIDTH-1:0] i_data;
  logic                        o_ready;
  logic                        i_flush;
  logic [DATA_WIDTH-1:0]       o_frame [FRAME_LEN];
  logic                        o_valid;
  logic                        i_out_ready;
  logic                        o_overflow;
  logic [CNT_W-1:0]            o_frame_cnt;

  modport slave (
    input  i_valid, i_data, i_flush, i_out_ready,
    output o_ready, o_frame, o_valid, o_overflow, o_frame_cnt
  );

  modport master (
    output i_valid, i_data, i_flush, i_out_ready,
    input  o_ready, o_frame, o_valid, o_overflow, o_frame_cnt
  );
endinterface

// File: rtl/ser_par_frame_collect.sv
// Collects LANES samples per beat into FRAME_LEN-sample frames and presents each
// completed frame from a dedicated output register so the next frame can fill meanwhile.
module ser_par_frame_collect #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int FRAME_LEN  = 16,
  parameter int ONE_SHOT   = 0,
  parameter int CNT_W      = 16
) (
  input logic                    clk,
  input logic                    i_rst,
  ser_par_frame_collect_if.slave bus
);
  localparam int PTR_W    = $clog2(FRAME_LEN + 1);
  localparam int LAST_PTR = FRAME_LEN - LANES;
  localparam int FILL_N   = (LAST_PTR > 0) ? LAST_PTR : 1;

  generate
    if (FRAME_LEN % LANES != 0) begin : gen_bad_cfg
      $error("ser_par_frame_collect: FRAME_LEN must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic {ST_FILL, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fill_q  [FILL_N];
  logic [DATA_WIDTH-1:0] fill_d  [FILL_N];
  logic [DATA_WIDTH-1:0] frame_q [FRAME_LEN];
  logic [DATA_WIDTH-1:0] frame_d [FRAME_LEN];
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] lane_data [LANES];
  logic                  last_beat;
  logic                  ready;
  logic                  accept;
  logic                  load;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gen_lane
      assign lane_data[gi] = bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Only the closing beat can stall: it needs the output register to be free.
  assign last_beat = (wr_ptr_q == PTR_W'(LAST_PTR));
  assign ready     = (state_q == ST_FILL) && !(last_beat && valid_q && !bus.i_out_ready);
  assign accept    = bus.i_valid && ready && !bus.i_flush;
  assign load      = accept && last_beat;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    if (bus.i_flush) begin
      wr_ptr_d   = '0;
      state_d    = ST_FILL;
      overflow_d = 1'b0;
    end else begin
      if (state_q == ST_DONE && bus.i_valid) begin
        overflow_d = 1'b1;
      end
      if (accept) begin
        if (last_beat) begin
          wr_ptr_d = '0;
          cnt_d    = cnt_q + CNT_W'(1);
          if (ONE_SHOT != 0) begin
            state_d = ST_DONE;
          end
        end else begin
          wr_ptr_d = wr_ptr_q + PTR_W'(LANES);
        end
      end
    end
    // A load and a drain in the same cycle keep o_valid high with no bubble.
    if (load) begin
      valid_d = 1'b1;
    end else if (bus.i_out_ready) begin
      valid_d = 1'b0;
    end
  end

  generate
    if (LAST_PTR > 0) begin : gen_fill
      for (gi = 0; gi < LAST_PTR; gi++) begin : gen_fill_entry
        assign fill_d[gi] = (accept && wr_ptr_q == PTR_W'((gi / LANES) * LANES))
                            ? lane_data[gi % LANES] : fill_q[gi];
      end
    end else begin : gen_no_fill
      assign fill_d[0] = fill_q[0];
    end

    for (gi = 0; gi < FRAME_LEN; gi++) begin : gen_frame
      if (gi < LAST_PTR) begin : gen_from_fill
        assign frame_d[gi] = load ? fill_q[gi] : frame_q[gi];
      end else begin : gen_from_lane
        assign frame_d[gi] = load ? lane_data[gi - LAST_PTR] : frame_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_FILL;
      wr_ptr_q   <= '0;
      fill_q     <= '{default: '0};
      frame_q    <= '{default: '0};
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_frame     = frame_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_frame_cnt = cnt_q;
endmodule

// File: tb/tb_ser_par_frame_collect.sv
// Drives a continuous and a one-shot collector with identical stimulus and checks
// both every cycle against a sample-count / frame-list reference model.
module tb_ser_par_frame_collect;
  localparam int DW = 32;
  localparam int LN = 2;
  localparam int FL = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           v    = 1'b0;
  logic [LN*DW-1:0] d  = '0;
  logic           fl   = 1'b0;
  logic           ordy = 1'b0;

  ser_par_frame_collect_if #(.DATA_WIDTH(DW), .LANES(LN), .FRAME_LEN(FL), .CNT_W(CW)) b0 ();
  ser_par_frame_collect_if #(.DATA_WIDTH(DW), .LANES(LN), .FRAME_LEN(FL), .CNT_W(CW)) b1 ();

  assign b0.i_valid = v;  assign b0.i_data = d;  assign b0.i_flush = fl;  assign b0.i_out_ready = ordy;
  assign b1.i_valid = v;  assign b1.i_data = d;  assign b1.i_flush = fl;  assign b1.i_out_ready = ordy;

  ser_par_frame_collect #(.DATA_WIDTH(DW), .LANES(LN), .FRAME_LEN(FL), .ONE_SHOT(0), .CNT_W(CW))
    u_cont (.clk(clk), .i_rst(rst), .bus(b0.slave));
  ser_par_frame_collect #(.DATA_WIDTH(DW), .LANES(LN), .FRAME_LEN(FL), .ONE_SHOT(1), .CNT_W(CW))
    u_once (.clk(clk), .i_rst(rst), .bus(b1.slave));

  // Reference model: samples collected so far, last delivered frame, flags.
  logic [DW-1:0] m_fill  [2][FL];
  logic [DW-1:0] m_frame [2][FL];
  int            m_n     [2];
  bit            m_valid [2];
  bit            m_done  [2];
  bit            m_ovf   [2];
  logic [CW-1:0] m_cnt   [2];
  bit            rdy_exp [2];
  bit            acc0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [FL*DW-1:0] obs, input logic [FL*DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [FL*DW-1:0] obs_frame(input int k);
    logic [FL*DW-1:0] r;
    for (int i = 0; i < FL; i++) r[i*DW +: DW] = (k == 0) ? b0.o_frame[i] : b1.o_frame[i];
    return r;
  endfunction

  function automatic logic [FL*DW-1:0] exp_frame(input int k);
    logic [FL*DW-1:0] r;
    for (int i = 0; i < FL; i++) r[i*DW +: DW] = m_frame[k][i];
    return r;
  endfunction

  function automatic logic [FL*DW-1:0] ramp_frame(input int base);
    logic [FL*DW-1:0] r;
    for (int i = 0; i < FL; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  function automatic logic [LN*DW-1:0] pat(input int k);
    logic [LN*DW-1:0] r;
    for (int l = 0; l < LN; l++) r[l*DW +: DW] = DW'(k * LN + l);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_valid[k] = 0; m_done[k] = 0; m_ovf[k] = 0; m_cnt[k] = '0;
      for (int i = 0; i < FL; i++) begin m_fill[k][i] = '0; m_frame[k][i] = '0; end
    end
  endtask

  function automatic bit model_ready(input int k);
    return !m_done[k] && !(m_n[k] == FL - LN && m_valid[k] && !ordy);
  endfunction

  task automatic model_step(input int k, input bit rdy);
    bit nf = 0;
    if (fl) begin
      m_n[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
    end else begin
      if (m_done[k] && v) m_ovf[k] = 1;
      if (v && rdy) begin
        for (int l = 0; l < LN; l++) m_fill[k][m_n[k] + l] = d[l*DW +: DW];
        m_n[k] += LN;
        if (m_n[k] == FL) begin
          for (int i = 0; i < FL; i++) m_frame[k][i] = m_fill[k][i];
          nf = 1;
          m_cnt[k] = m_cnt[k] + 1'b1;
          m_n[k] = 0;
          if (k == 1) m_done[k] = 1;
        end
      end
    end
    m_valid[k] = nf ? 1'b1 : (ordy ? 1'b0 : m_valid[k]);
  endtask

  task automatic check_out();
    chk("valid0", b0.o_valid, m_valid[0]);
    chk("cnt0", b0.o_frame_cnt, m_cnt[0]);
    chk("ovf0", b0.o_overflow, m_ovf[0]);
    chk("frame0", obs_frame(0), exp_frame(0));
    chk("valid1", b1.o_valid, m_valid[1]);
    chk("cnt1", b1.o_frame_cnt, m_cnt[1]);
    chk("ovf1", b1.o_overflow, m_ovf[1]);
    chk("frame1", obs_frame(1), exp_frame(1));
  endtask

  // One clock: drive at negedge, check ready, step model at posedge, check outputs.
  task automatic cycle(input bit vv, input logic [LN*DW-1:0] dd, input bit ff, input bit rr);
    @(negedge clk);
    v = vv; d = dd; fl = ff; ordy = rr;
    #1;
    for (int k = 0; k < 2; k++) rdy_exp[k] = model_ready(k);
    chk("ready0", b0.o_ready, rdy_exp[0]);
    chk("ready1", b1.o_ready, rdy_exp[1]);
    @(posedge clk);
    acc0 = v && rdy_exp[0] && !fl;
    for (int k = 0; k < 2; k++) model_step(k, rdy_exp[k]);
    #1;
    check_out();
  endtask

  // Offer beat k to the continuous collector until taken, with a bounded wait.
  task automatic beat(input int k, input bit rr);
    int tries = 0;
    do begin
      cycle(1'b1, pat(k), 1'b0, rr);
      tries++;
    end while (!acc0 && tries < 20);
    chk("beat_accept", acc0, 1'b1);
  endtask

  task automatic idle(input bit rr);
    cycle(1'b0, '0, 1'b0, rr);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", b0.o_ready, 1'b1);
    check_out();

    // T1: one frame, held by consumer
    for (int k = 0; k < 8; k++) beat(k, 1'b0);
    chk("t1_valid", b0.o_valid, 1'b1);
    chk("t1_cnt", b0.o_frame_cnt, 16'd1);
    chk("t1_frame", obs_frame(0), ramp_frame(0));
    idle(1'b1);

    // T2: four frames back-to-back, consumer always ready
    for (int k = 0; k < 32; k++) beat(k, 1'b1);
    chk("t2_cnt", b0.o_frame_cnt, 16'd5);
    chk("t2_frame", obs_frame(0), ramp_frame(48));
    idle(1'b1);

    // T3: consumer stalls, closing beat must wait
    for (int k = 0; k < 8; k++) beat(k, 1'b1);
    for (int k = 8; k < 15; k++) beat(k, 1'b0);
    repeat (3) begin
      cycle(1'b1, pat(15), 1'b0, 1'b0);
      chk("t3_stall", b0.o_ready, 1'b0);
      chk("t3_hold", obs_frame(0), ramp_frame(0));
    end
    beat(15, 1'b1);
    chk("t3_frame2", obs_frame(0), ramp_frame(16));
    idle(1'b1);

    // T4: one-shot done, overflow, re-arm
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) beat(k, 1'b1);
    chk("t4_done_ready", b1.o_ready, 1'b0);
    cycle(1'b1, pat(40), 1'b0, 1'b1);
    cycle(1'b1, pat(41), 1'b0, 1'b1);
    chk("t4_ovf", b1.o_overflow, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("t4_ovf_clr", b1.o_overflow, 1'b0);
    chk("t4_rearm", b1.o_ready, 1'b1);
    for (int k = 8; k < 16; k++) beat(k, 1'b1);
    chk("t4_frame", obs_frame(1), ramp_frame(16));
    idle(1'b1);

    // T5: flush with a simultaneous beat
    for (int k = 0; k < 3; k++) beat(k + 20, 1'b1);
    cycle(1'b1, pat(99), 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) beat(k, 1'b0);
    chk("t5_frame", obs_frame(0), ramp_frame(0));
    idle(1'b1);

    // T6: reset in the middle of the second frame
    for (int k = 0; k < 8; k++) beat(k, 1'b1);
    for (int k = 8; k < 12; k++) beat(k, 1'b1);
    @(negedge clk);
    v = 1'b1; d = pat(12); rst = 1'b1;
    #1;
    model_reset();
    chk("t6_valid", b0.o_valid, 1'b0);
    chk("t6_cnt", b0.o_frame_cnt, 16'd0);
    chk("t6_frame", obs_frame(0), ramp_frame(0) & '0);
    @(negedge clk);
    rst = 1'b0; v = 1'b0;
    for (int k = 4; k < 12; k++) beat(k, 1'b0);
    chk("t6_after", obs_frame(0), ramp_frame(8));
    idle(1'b1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, {$urandom, $urandom},
            $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
